// File: rtl/ser_pkg.sv
// Serial line package: FSM state encoding, line levels and default frame geometry.
// Shared between the transmit shifter and the serial-in receiver side.
package ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 1;

endpackage

// File: rtl/ser_tx_shifter_baud.sv
// Bit-period divider: pulses tick on the last of every DIV cycles while en is high.
// Counter is held at zero whenever en is low, so each frame starts on a full bit period.
module ser_baud_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser_tx_shifter.sv
// Parallel-in serial-out frame transmitter: start, WIDTH data bits MSB-first, stop; 1-cycle latency.
// Optional even parity bit before stop when SER_TX_PARITY_EN is defined.
module ser_tx_shifter
    import ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_oe,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             tick;
    logic             baud_en;
    logic             accept;
    logic             line_nxt;
`ifdef SER_TX_PARITY_EN
    logic             par;
`endif

    assign tx_ready = (state == IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign baud_en  = (state != IDLE);

    ser_baud_div #(
        .DIV (DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en),
        .tick (tick)
    );

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        line_nxt    = LINE_IDLE;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    shreg_nxt = tx_data;
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = shreg << 1;
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        bit_cnt_nxt = '0;
`ifdef SER_TX_PARITY_EN
                        state_nxt   = PARITY;
`else
                        state_nxt   = STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
`ifdef SER_TX_PARITY_EN
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is registered, so it is derived from where the FSM is heading.
        case (state_nxt)
            START:   line_nxt = START_BIT;
            DATA:    line_nxt = shreg_nxt[WIDTH-1];
`ifdef SER_TX_PARITY_EN
            PARITY:  line_nxt = par;
`endif
            STOP:    line_nxt = STOP_BIT;
            default: line_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ser_out <= LINE_IDLE;
            ser_oe  <= 1'b0;
            busy    <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            ser_out <= line_nxt;
            ser_oe  <= (state_nxt != IDLE);
            busy    <= (state_nxt != IDLE);
`ifdef SER_TX_PARITY_EN
            if (accept) par <= ^tx_data;
`endif
        end
    end

endmodule
